fifo_8_to_32: RTL and testbench

Receive-direction counterpart of the 32-to-8 transmit FIFO. It takes the byte stream from the SiTCP TCP RX FIFO interface and packs it into 32-bit words in a show-ahead FIFO. Words are read in the BUS_CLK domain by a downstream consumer, for example a command/register sink. It also supplies a free-space count suitable for driving TCP_RX_WC, so SiTCP throttles before data is lost.

---
 rtl/fifo_8_to_32.sv | 129 ++++++++++++
 tb/tb_fifo_8_to_32.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_8_to_32.sv
// Byte-to-word receive FIFO: packs the SiTCP RX byte stream LSB-first into 32-bit words
// and holds them in a show-ahead FIFO, reporting free space in bytes for TCP_RX_WC.
module fifo_8_to_32 #(
   parameter int DEPTH    = 256,
   parameter int WC_WIDTH = 16
) (
   input  logic                BUS_CLK,
   input  logic                BUS_RST_N,
   input  logic                FLUSH,
   input  logic                WRITE,
   input  logic [7:0]          DATA_IN,
   input  logic                READ,
   output logic [31:0]         DATA_OUT,
   output logic                EMPTY,
   output logic                FULL,
   output logic [1:0]          PARTIAL,
   output logic [WC_WIDTH-1:0] FREE_BYTES,
   output logic                OVERFLOW
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam longint MAXV = (longint'(1) << WC_WIDTH) - 1;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] rd_nxt;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    part_q, part_d;
   logic          ovf_q, ovf_d;
   logic [23:0]   pack_q, pack_d;
   logic [31:0]   head_q, head_d;
   logic [31:0]   word;
   logic          done, do_push, do_pop;

   // Saturating, floored free-space count; full FIFO with bytes in the packer goes negative.
   function automatic logic [WC_WIDTH-1:0] free_sat(input logic [CW-1:0] cnt,
                                                    input logic [1:0]    part);
      logic signed [CW+3:0] v;
      v = $signed({2'b00, DEPTH_C - cnt, 2'b00}) - $signed({{(CW + 2){1'b0}}, part});
      if (v < 0)
         return '0;
      else if (longint'(v) > MAXV)
         return WC_WIDTH'(MAXV);
      else
         return WC_WIDTH'(v);
   endfunction

   assign EMPTY      = (count_q == '0);
   assign FULL       = (count_q == DEPTH_C);
   assign PARTIAL    = part_q;
   assign OVERFLOW   = ovf_q;
   assign DATA_OUT   = head_q;
   assign FREE_BYTES = free_sat(count_q, part_q);

   assign word    = {DATA_IN, pack_q};
   assign rd_nxt  = rd_ptr_q + AW'(1);
   assign done    = WRITE && (part_q == 2'd3);
   assign do_pop  = !FLUSH && READ && !EMPTY;
   assign do_push = !FLUSH && done && (!FULL || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      part_d   = part_q;
      ovf_d    = ovf_q;
      pack_d   = pack_q;
      head_d   = head_q;
      if (FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         part_d   = '0;
         ovf_d    = 1'b0;
      end else begin
         if (WRITE) begin
            part_d = part_q + 2'd1;
            case (part_q)
               2'd0:    pack_d[7:0]   = DATA_IN;
               2'd1:    pack_d[15:8]  = DATA_IN;
               2'd2:    pack_d[23:16] = DATA_IN;
               default: pack_d        = pack_q;
            endcase
         end
         if (done && !do_push)
            ovf_d = 1'b1;
         if (do_push)
            wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)
            rd_ptr_d = rd_nxt;
         if (do_push && !do_pop)
            count_d = count_q + CW'(1);
         else if (do_pop && !do_push)
            count_d = count_q - CW'(1);
         // Head is a prefetch register: refill from RAM on pop, bypass the new word into an empty head.
         if (do_pop && count_q != CW'(1))
            head_d = mem[rd_nxt];
         else if (do_push && (count_q == '0 || do_pop))
            head_d = word;
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         part_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         part_q   <= part_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge BUS_CLK) begin
      pack_q <= pack_d;
      head_q <= head_d;
      if (do_push)
         mem[wr_ptr_q] <= word;
   end

endmodule

// File: tb/tb_fifo_8_to_32.sv
// Bench for fifo_8_to_32: vector table for packing/show-ahead timing, scoreboard queue for
// fill/overflow/drain, plus flush and asynchronous reset sequences.
module tb_fifo_8_to_32;

   localparam int DEPTH = 256;
   localparam int WCW   = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           flush = 1'b0;
   logic           wr = 1'b0;
   logic [7:0]     din = '0;
   logic           rd = 1'b0;
   logic [31:0]    dout;
   logic           empty, full, ovf;
   logic [1:0]     part;
   logic [WCW-1:0] free;

   int checks = 0;
   int failures = 0;
   logic [31:0] sb_q[$];

   typedef struct {
      logic        wr;
      logic [7:0]  din;
      logic        rd;
      logic        fl;
      logic        exp_empty;
      logic [1:0]  exp_part;
      logic [15:0] exp_free;
      logic        chk_data;
      logic [31:0] exp_data;
   } vec_t;
   vec_t vecs[$];

   fifo_8_to_32 #(.DEPTH(DEPTH), .WC_WIDTH(WCW)) dut (
      .BUS_CLK(clk), .BUS_RST_N(rst_n), .FLUSH(flush), .WRITE(wr), .DATA_IN(din),
      .READ(rd), .DATA_OUT(dout), .EMPTY(empty), .FULL(full), .PARTIAL(part),
      .FREE_BYTES(free), .OVERFLOW(ovf));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [7:0] d, input logic r, input logic f,
                               input logic e, input logic [1:0] p, input logic [15:0] fr,
                               input logic cd, input logic [31:0] ed);
      vec_t v;
      v.wr = w; v.din = d; v.rd = r; v.fl = f;
      v.exp_empty = e; v.exp_part = p; v.exp_free = fr; v.chk_data = cd; v.exp_data = ed;
      return v;
   endfunction

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         wr = 1'b1;
         din = w[8*i +: 8];
         step();
      end
      wr = 1'b0;
   endtask

   task automatic fill_fifo();
      logic [31:0] w;
      for (int i = 0; i < DEPTH; i++) begin
         w = $urandom;
         send_word(w);
         sb_q.push_back(w);
      end
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] exp_w;

      // Reset state
      step();
      step();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_partial", 32'(part), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_free", 32'(free), 32'd1024);
      rst_n = 1'b1;
      step();

      // Packing order, latency, pause with partial word, reads including read on empty
      vecs.push_back(mk(1, 8'h11, 0, 0, 1, 2'd1, 16'd1023, 0, 32'h0));
      vecs.push_back(mk(1, 8'h22, 0, 0, 1, 2'd2, 16'd1022, 0, 32'h0));
      vecs.push_back(mk(1, 8'h33, 0, 0, 1, 2'd3, 16'd1021, 0, 32'h0));
      vecs.push_back(mk(1, 8'h44, 0, 0, 0, 2'd0, 16'd1020, 1, 32'h44332211));
      vecs.push_back(mk(0, 8'h00, 1, 0, 1, 2'd0, 16'd1024, 0, 32'h0));
      vecs.push_back(mk(1, 8'hAA, 0, 0, 1, 2'd1, 16'd1023, 0, 32'h0));
      vecs.push_back(mk(1, 8'hBB, 0, 0, 1, 2'd2, 16'd1022, 0, 32'h0));
      vecs.push_back(mk(1, 8'hCC, 0, 0, 1, 2'd3, 16'd1021, 0, 32'h0));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(0, 8'h00, 0, 0, 1, 2'd3, 16'd1021, 0, 32'h0));
      vecs.push_back(mk(1, 8'hDD, 0, 0, 0, 2'd0, 16'd1020, 1, 32'hDDCCBBAA));
      vecs.push_back(mk(0, 8'h00, 1, 0, 1, 2'd0, 16'd1024, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 1, 2'd0, 16'd1024, 0, 32'h0));

      foreach (vecs[i]) begin
         wr = vecs[i].wr; din = vecs[i].din; rd = vecs[i].rd; flush = vecs[i].fl;
         step();
         wr = 1'b0; rd = 1'b0; flush = 1'b0;
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
         chk($sformatf("vec%0d_partial", i), 32'(part), 32'(vecs[i].exp_part));
         chk($sformatf("vec%0d_free", i), 32'(free), 32'(vecs[i].exp_free));
         if (vecs[i].chk_data)
            chk($sformatf("vec%0d_data", i), dout, vecs[i].exp_data);
      end

      // Fill to capacity
      fill_fifo();
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_free", 32'(free), 32'd0);
      chk("fill_head", dout, sb_q[0]);

      // Completing byte while full with a pop on the same edge
      w = 32'hA1B2C3D4;
      for (int i = 0; i < 3; i++) begin
         wr = 1'b1; din = w[8*i +: 8];
         step();
      end
      chk("full_part3_free_floor", 32'(free), 32'd0);
      chk("full_part3_partial", 32'(part), 32'd3);
      wr = 1'b1; din = w[31:24]; rd = 1'b1;
      exp_w = sb_q.pop_front();
      chk("pushpop_head_before", dout, exp_w);
      step();
      wr = 1'b0; rd = 1'b0;
      sb_q.push_back(w);
      chk("pushpop_ovf", 32'(ovf), 32'd0);
      chk("pushpop_full", 32'(full), 32'd1);
      chk("pushpop_head_after", dout, sb_q[0]);

      // Completing a word while full without a pop drops it
      send_word(32'hDEAD0001);
      chk("ovf_set", 32'(ovf), 32'd1);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_partial", 32'(part), 32'd0);
      chk("ovf_head_unchanged", dout, sb_q[0]);

      // Drain in order; last word is the one pushed with the simultaneous pop
      for (int i = 0; i < DEPTH; i++) begin
         exp_w = sb_q.pop_front();
         chk($sformatf("drain%0d", i), dout, exp_w);
         chk($sformatf("drain%0d_empty", i), 32'(empty), 32'd0);
         rd = 1'b1;
         step();
      end
      rd = 1'b0;
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_ovf_sticky", 32'(ovf), 32'd1);
      chk("drain_free", 32'(free), 32'd1024);

      // FLUSH beats WRITE and READ
      send_word(32'h01020304);
      send_word(32'h05060708);
      wr = 1'b1; din = 8'h99; step();
      wr = 1'b1; din = 8'h98; step();
      wr = 1'b0;
      chk("preflush_partial", 32'(part), 32'd2);
      chk("preflush_head", dout, 32'h01020304);
      chk("preflush_free", 32'(free), 32'd1014);
      flush = 1'b1; wr = 1'b1; din = 8'h77; rd = 1'b1;
      step();
      flush = 1'b0; wr = 1'b0; rd = 1'b0;
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_partial", 32'(part), 32'd0);
      chk("flush_ovf", 32'(ovf), 32'd0);
      chk("flush_full", 32'(full), 32'd0);
      chk("flush_free", 32'(free), 32'd1024);
      send_word(32'hCAFEF00D);
      chk("postflush_head", dout, 32'hCAFEF00D);
      rd = 1'b1; step(); rd = 1'b0;
      chk("postflush_empty", 32'(empty), 32'd1);

      // Asynchronous reset mid-stream
      sb_q.delete();
      fill_fifo();
      send_word(32'hDEAD0002);
      chk("pre_arst_ovf", 32'(ovf), 32'd1);
      wr = 1'b1; din = 8'h55; step(); wr = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_full", 32'(full), 32'd0);
      chk("arst_ovf", 32'(ovf), 32'd0);
      chk("arst_partial", 32'(part), 32'd0);
      chk("arst_free", 32'(free), 32'd1024);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      send_word(32'h87654321);
      chk("post_arst_empty", 32'(empty), 32'd0);
      chk("post_arst_head", dout, 32'h87654321);
      chk("post_arst_free", 32'(free), 32'd1020);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
